// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner with frame-based debounce and press/release events
module keypad_scanner #(
  parameter int ROWS = 4,
  parameter int COLS = 3,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  localparam int CODE_W = $clog2(ROWS * COLS)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [COLS-1:0]   cols,
  output logic [ROWS-1:0]   rows,
  output logic [CODE_W-1:0] keycode,
  output logic              key_valid,
  output logic              key_release,
  output logic              key_held,
  output logic              multi_err
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  localparam int NW = $clog2(DEBOUNCE + 1);
  typedef enum logic [1:0] {IDLE, DEB, PRESSED, RELEASE} state_t;
  state_t state;
  logic [DW-1:0] div;
  logic [RW-1:0] ridx;
  logic [1:0] acc_n, row_n, f_n;
  logic [CODE_W-1:0] acc_k, row_k, f_k, cand;
  logic [NW-1:0] cnt;
  logic tick, fe;
  assign tick = div == DW'(SCAN_DIV - 1);
  assign fe = tick && ridx == RW'(ROWS - 1);
  assign rows = ~(ROWS'(1) << ridx);
  assign key_held = state == PRESSED || state == RELEASE;
  // count closed columns on the strobed row (saturating at 2) and fold into the frame tally
  always_comb begin
    row_n = 2'd0;
    row_k = '0;
    for (int c = 0; c < COLS; c++)
      if (!cols[c]) begin
        row_n = row_n == 2'd0 ? 2'd1 : 2'd2;
        row_k = CODE_W'(int'(ridx) * COLS + c);
      end
    f_n = acc_n == 2'd0 ? row_n : row_n == 2'd0 ? acc_n : 2'd2;
    f_k = acc_n == 2'd0 ? row_k : acc_k;
  end
  // dwell counter, row rotation and per-frame accumulation, sampled on the settled last dwell cycle
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div <= '0;
      ridx <= '0;
      acc_n <= 2'd0;
      acc_k <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        ridx <= fe ? '0 : ridx + 1'b1;
        acc_n <= fe ? 2'd0 : f_n;
        acc_k <= fe ? '0 : f_k;
      end
    end
  end
  // debounce FSM stepped once per frame; event outputs are registered single-cycle pulses
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      cand <= '0;
      keycode <= '0;
      key_valid <= 1'b0;
      key_release <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      key_release <= 1'b0;
      multi_err <= fe && f_n == 2'd2;
      if (fe)
        case (state)
          IDLE:
            if (f_n == 2'd1) begin
              cand <= f_k;
              cnt <= NW'(1);
              if (DEBOUNCE == 1) begin
                state <= PRESSED;
                keycode <= f_k;
                key_valid <= 1'b1;
              end else state <= DEB;
            end
          DEB:
            if (f_n != 2'd1) state <= IDLE;
            else if (f_k != cand) begin
              cand <= f_k;
              cnt <= NW'(1);
            end else if (cnt + 1'b1 == NW'(DEBOUNCE)) begin
              state <= PRESSED;
              keycode <= cand;
              key_valid <= 1'b1;
            end else cnt <= cnt + 1'b1;
          PRESSED:
            if (f_n == 2'd0) begin
              cnt <= NW'(1);
              if (DEBOUNCE == 1) begin
                state <= IDLE;
                key_release <= 1'b1;
              end else state <= RELEASE;
            end
          RELEASE:
            if (f_n != 2'd0) begin
              state <= PRESSED;
              cnt <= '0;
            end else if (cnt + 1'b1 == NW'(DEBOUNCE)) begin
              state <= IDLE;
              key_release <= 1'b1;
            end else cnt <= cnt + 1'b1;
          default: state <= IDLE;
        endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad frames checked against a streak-counting reference model
module tb_keypad_scanner;
  localparam int R = 4, C = 3, S = 4, D = 3, F = R * S;
  logic clk = 1'b0, reset = 1'b1;
  logic [C-1:0] cols;
  logic [R-1:0] rows;
  logic [3:0] keycode;
  logic key_valid, key_release, key_held, multi_err;
  logic [R*C-1:0] pressed = '0;
  int n = 0, errors = 0, checks = 0;
  int cand = -1, streak = 0, quiet = 0, kc = 0;
  bit held = 0, ev, er, em;

  keypad_scanner #(.ROWS(R), .COLS(C), .SCAN_DIV(S), .DEBOUNCE(D)) dut (
    .CLOCK_50(clk), .reset(reset), .cols(cols), .rows(rows), .keycode(keycode),
    .key_valid(key_valid), .key_release(key_release), .key_held(key_held), .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  // physical keypad: a closed key pulls its column low while its row is strobed
  always_comb begin
    cols = '1;
    for (int c = 0; c < C; c++)
      for (int r = 0; r < R; r++)
        if (!rows[r] && pressed[r*C+c]) cols[c] = 1'b0;
  end

  function automatic logic [11:0] key(input int k);
    logic [11:0] one = 12'd1;
    return one << k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, n);
    end
  endtask

  // classify the frame's key set and advance the press/release streak model
  task automatic judge();
    int nk = $countones(pressed);
    int k = -1;
    int r;
    for (int i = 0; i < R * C; i++) if (pressed[i]) k = i;
    r = nk == 0 ? -1 : nk == 1 ? k : -2;
    em = nk >= 2;
    if (!held) begin
      if (r >= 0) begin
        if (r == cand) streak++;
        else begin
          cand = r;
          streak = 1;
        end
        if (streak == D) begin
          held = 1;
          kc = cand;
          ev = 1;
          cand = -1;
          streak = 0;
        end
      end else begin
        cand = -1;
        streak = 0;
      end
    end else if (r == -1) begin
      quiet++;
      if (quiet == D) begin
        held = 0;
        quiet = 0;
        er = 1;
      end
    end else quiet = 0;
  endtask

  task automatic cycle();
    logic [3:0] erows;
    @(posedge clk);
    #1;
    ev = 0;
    er = 0;
    em = 0;
    if (reset) begin
      n = 0;
      held = 0;
      cand = -1;
      streak = 0;
      quiet = 0;
      kc = 0;
    end else begin
      n++;
      if (n % F == 0) judge();
    end
    erows = ~(4'b0001 << ((n / S) % R));
    chk("rows", rows, erows);
    chk("keycode", keycode, kc);
    chk("key_valid", key_valid, ev);
    chk("key_release", key_release, er);
    chk("key_held", key_held, held);
    chk("multi_err", multi_err, em);
  endtask

  task automatic frames(input logic [11:0] p, input int nf);
    pressed = p;
    repeat (nf * F) cycle();
  endtask

  initial begin
    logic [11:0] seq [$];
    logic [11:0] p;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    seq = '{12'h0, 12'h0, key(7), key(7), key(7), key(7), 12'h0, 12'h0, key(7),
            12'h0, 12'h0, 12'h0, key(7), 12'h0, key(7), key(7), key(7), 12'h0, 12'h0, 12'h0,
            key(0) | key(5), key(0) | key(5), key(0) | key(5), key(3), key(3), key(3),
            key(3) | key(11), key(3) | key(11), key(3), 12'h0, 12'h0, 12'h0,
            key(1), key(2), key(2), key(2), 12'h0, 12'h0, 12'h0};
    foreach (seq[i]) frames(seq[i], 1);
    pressed = key(7);
    repeat (2 * F + 5) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    frames(key(7), 3);
    frames(12'h0, 3);
    p = 12'h0;
    repeat (150) begin
      case ($urandom_range(9))
        0, 1, 2, 3: p = p;
        4, 5: p = 12'h0;
        6, 7, 8: p = key($urandom_range(11));
        default: p = key($urandom_range(11)) | key($urandom_range(11));
      endcase
      frames(p, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
